alu_iter_exec: RTL

ALU_ITER_EXEC -- requirements
Module: alu_iter_exec

---
 rtl/alu_iter_exec_if.sv | 23 ++
 rtl/alu_iter_exec.sv | 112 +++++++++++
 2 files changed

// File: rtl/alu_iter_exec_if.sv
// rtl/alu_iter_exec_if.sv - request/result handshake bundle for alu_iter_exec
interface alu_iter_exec_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct;
    logic        add_rshift_type;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Out;

    modport master (
        output in_valid, opcode, funct, add_rshift_type, A, B, out_ready,
        input  in_ready, out_valid, Out
    );

    modport slave (
        input  in_valid, opcode, funct, add_rshift_type, A, B, out_ready,
        output in_ready, out_valid, Out
    );
endinterface

// File: rtl/alu_iter_exec.sv
// rtl/alu_iter_exec.sv - RV32I ALU with iterative shifter and valid/ready handshakes
module alu_iter_exec #(
    parameter int SHIFT_STEP = 1
) (
    input  logic           Clock,
    input  logic           Reset,
    alu_iter_exec_if.slave bus
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [4:0] STEP    = 5'(SHIFT_STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, next_state;
    logic [31:0] out_q;
    logic [31:0] work;
    logic [4:0]  remaining;
    logic        sh_left;
    logic        sh_arith;

    logic [31:0] res;
    logic        is_shift;
    logic        accept;
    logic        start_shift;
    logic [4:0]  step;
    logic [4:0]  rem_next;
    logic [31:0] work_next;

    // Combinational decode of the live request; only sampled on accept.
    always_comb begin
        res      = 32'h0;
        is_shift = 1'b0;
        case (bus.opcode)
            OP_R, OP_I: begin
                case (bus.funct)
                    3'b000: res = (bus.opcode == OP_R && bus.add_rshift_type) ?
                                  bus.A - bus.B : bus.A + bus.B;
                    3'b001: begin is_shift = 1'b1; res = bus.A; end
                    3'b010: res = {31'h0, $signed(bus.A) < $signed(bus.B)};
                    3'b011: res = {31'h0, bus.A < bus.B};
                    3'b100: res = bus.A ^ bus.B;
                    3'b101: begin is_shift = 1'b1; res = bus.A; end
                    3'b110: res = bus.A | bus.B;
                    default: res = bus.A & bus.B;
                endcase
            end
            OP_LUI: res = bus.B;
            7'b0000011, 7'b0100011, 7'b0010111,
            7'b1101111, 7'b1100111, 7'b1100011: res = bus.A + bus.B;
            default: res = 32'h0;
        endcase
    end

    assign accept      = bus.in_valid && (state == IDLE);
    assign start_shift = is_shift && (bus.B[4:0] != 5'd0);

    assign step      = (remaining < STEP) ? remaining : STEP;
    assign rem_next  = remaining - step;
    assign work_next = sh_left  ? (work << step) :
                       sh_arith ? 32'($signed(work) >>> step) :
                                  (work >> step);

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = start_shift ? SHIFT : DONE;
            SHIFT:   if (rem_next == 5'd0) next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_q     <= 32'h0;
            work      <= 32'h0;
            remaining <= 5'd0;
            sh_left   <= 1'b0;
            sh_arith  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (start_shift) begin
                        work      <= bus.A;
                        remaining <= bus.B[4:0];
                        sh_left   <= (bus.funct == 3'b001);
                        sh_arith  <= bus.add_rshift_type;
                    end else begin
                        out_q <= res;
                    end
                end
                SHIFT: begin
                    work      <= work_next;
                    remaining <= rem_next;
                    if (rem_next == 5'd0) out_q <= work_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.Out       = out_q;
endmodule
